l1_dm_cache: RTL
================

// Module: l1_dm_cache
// PURPOSE
//  Direct-mapped, write-back, write-allocate L1 cache that is the responder on the CPU-side
//  read/write/mbe/resp interface; one instance serves the instruction port, one the data port.
//  On a miss it becomes the initiator on a 256-bit line-granular physical-memory (pmem) port.
//  Hits complete in one cycle; misses write back a dirty victim, then fill.
// PARAMETERS
//  S_INDEX  4    set-index bits; NUM_SETS = 2**S_INDEX (default 16 lines)
//  S_OFFSET 5    line-offset bits; line = 32 B = 256 b (fixed, packaged constant)
// PORTS
//  clk              in   1    clock; every register updates on posedge
//  rst              in   1    reset, synchronous, active-high
//  mem_address      in   32   CPU byte address; bits [1:0] ignored
//  mem_read         in   1    CPU read request; held stable until mem_resp
//  mem_write        in   1    CPU write request; held stable until mem_resp
//  mem_wdata        in   32   write data, byte lanes already positioned
//  mem_byte_enable  in   4    byte-lane mask for writes; ignored on reads
//  mem_rdata        out  32   read data, valid while mem_resp=1
//  mem_resp         out  1    one-cycle completion pulse
//  pmem_address     out  32   line-aligned address ([4:0]=0)
//  pmem_read        out  1    line fill request, held until pmem_resp
//  pmem_write       out  1    line writeback request, held until pmem_resp
//  pmem_wdata       out  256  victim line data
//  pmem_rdata       in   256  fill line data, valid with pmem_resp
//  pmem_resp        in   1    pmem completion pulse
// BEHAVIOUR
//  - Address split: tag=[31:S_INDEX+5], index=[S_INDEX+4:5], word=[4:2].
//  - State machine IDLE -> (WRITEBACK) -> FILL -> IDLE; reset state IDLE.
//  - IDLE, no request: all outputs 0. Request with valid && tag match = hit:
//    mem_resp=1 same cycle (combinational array read); read: mem_rdata=line word[word];
//    write: bytes with mbe bit set merged into the line at posedge, dirty<=1 (even if mbe=0).
//  - IDLE, request miss: victim dirty -> WRITEBACK, else -> FILL. mem_resp stays 0.
//  - WRITEBACK: pmem_write=1, pmem_address={stored tag,index,5'b0}, pmem_wdata=victim line;
//    on pmem_resp: dirty<=0, -> FILL.
//  - FILL: pmem_read=1, pmem_address={req tag,index,5'b0}; on pmem_resp: data<=pmem_rdata,
//    tag<=req tag, valid<=1, dirty<=0, -> IDLE; the following cycle the request hits.
//  - Miss latency = pmem latencies + 1 cycle; no hit-under-miss, one outstanding request.
//  - mem_read && mem_write together: treated as write.
//  - pmem_resp outside WRITEBACK/FILL: ignored.
//  - Reset (any state, incl. mid-WRITEBACK/FILL): next cycle state=IDLE, all valid and dirty
//    bits 0, pmem_read/pmem_write/mem_resp 0; data/tag arrays not cleared. An in-flight pmem
//    transaction is abandoned; its late pmem_resp is ignored.
//  - mem_rdata is 0 when mem_resp=0.
// STRUCTURE
//  - Package cache_types: S_OFFSET, LINE_BITS=256, tag/index width functions of S_INDEX,
//    state enum cache_state_t {IDLE, WRITEBACK, FILL}.
//  - Sub-module cache_array #(WIDTH): NUM_SETS entries, async read, sync write with load,
//    sync clear on rst (clear used for valid/dirty only). Four instances: data, tag, valid, dirty.
//  - Top holds FSM, hit compare, byte-merge of 32-bit write into 256-bit line.
// TESTING
//  - Cold read 0x0000_0040 after rst: pmem_read, address 0x40, no pmem_write; fill line with
//    word1=0xDEADBEEF; read 0x44 -> mem_rdata=0xDEADBEEF, mem_resp on cycle after fill.
//  - Write hit 0x44 data 0x0000AB00 mbe=0010 -> one-cycle resp; read 0x44 -> 0xDEADABEF.
//  - Conflict read 0x0000_0240 (same index 2, S_INDEX=4) with line dirty -> pmem_write addr
//    0x40 carrying 0xDEADABEF in word1, then pmem_read addr 0x240, then resp.
//  - Reset asserted mid-FILL: next cycle pmem_read=0, state IDLE; earlier-resident 0x40 read
//    then misses (valid cleared); stray pmem_resp in IDLE produces no mem_resp.
//  - Clean eviction: read miss on clean victim -> no pmem_write, FILL only.
//  - Simultaneous read+write hit with mbe=1111 -> line written, dirty set, single mem_resp.

Source files
------------

// File: rtl/l1_dm_cache_pkg.sv
// cache_types: shared constants, width helpers and FSM state type for l1_dm_cache
package cache_types;
    localparam int S_OFFSET  = 5;
    localparam int LINE_BITS = 256;

    function automatic int tag_bits(input int s_index);
        return 32 - s_index - S_OFFSET;
    endfunction

    function automatic int index_bits(input int s_index);
        return s_index;
    endfunction

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} cache_state_t;
endpackage

// File: rtl/l1_dm_cache_array.sv
// cache_array: NUM_SETS x WIDTH storage, async read, sync write on load, sync clear on clr
//   clk, clr (clears every entry), load (writes din at idx), idx, din, dout (entry at idx)
module cache_array #(
    parameter int WIDTH   = 1,
    parameter int S_INDEX = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               load,
    input  logic [S_INDEX-1:0] idx,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout
);
    localparam int NUM_SETS = 2 ** S_INDEX;

    logic [WIDTH-1:0] mem [NUM_SETS];

    always_ff @(posedge clk) begin
        if (clr)
            for (int i = 0; i < NUM_SETS; i++) mem[i] <= '0;
        else if (load)
            mem[idx] <= din;
    end

    assign dout = mem[idx];
endmodule

// File: rtl/l1_dm_cache.sv
// l1_dm_cache: direct-mapped write-back write-allocate L1 cache
//   CPU side : mem_address/read/write/wdata/byte_enable in, mem_rdata/mem_resp out
//   pmem side: pmem_address/read/write/wdata out, pmem_rdata/pmem_resp in (256-bit lines)
module l1_dm_cache
    import cache_types::*;
#(
    parameter int S_INDEX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          mem_address,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_byte_enable,
    output logic [31:0]          mem_rdata,
    output logic                 mem_resp,
    output logic [31:0]          pmem_address,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [LINE_BITS-1:0] pmem_wdata,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);
    localparam int TAG_W = tag_bits(S_INDEX);
    localparam int IDX_W = index_bits(S_INDEX);

    cache_state_t         state, next_state;
    logic [TAG_W-1:0]     req_tag, tag_q;
    logic [IDX_W-1:0]     index;
    logic [2:0]           word;
    logic [LINE_BITS-1:0] line_q, line_d, merged;
    logic                 valid_q, dirty_q, valid_d, dirty_d, hit, req;
    logic                 data_ld, tag_ld, valid_ld, dirty_ld;
    logic                 unused_addr;

    assign req_tag     = mem_address[31:S_OFFSET+IDX_W];
    assign index       = mem_address[S_OFFSET+IDX_W-1:S_OFFSET];
    assign word        = mem_address[4:2];
    assign unused_addr = ^mem_address[1:0];
    assign req         = mem_read | mem_write;
    assign hit         = valid_q && (tag_q == req_tag);

    cache_array #(.WIDTH(LINE_BITS), .S_INDEX(S_INDEX)) u_data (
        .clk(clk), .clr(1'b0), .load(data_ld), .idx(index), .din(line_d), .dout(line_q));
    cache_array #(.WIDTH(TAG_W), .S_INDEX(S_INDEX)) u_tag (
        .clk(clk), .clr(1'b0), .load(tag_ld), .idx(index), .din(req_tag), .dout(tag_q));
    cache_array #(.WIDTH(1), .S_INDEX(S_INDEX)) u_valid (
        .clk(clk), .clr(rst), .load(valid_ld), .idx(index), .din(valid_d), .dout(valid_q));
    cache_array #(.WIDTH(1), .S_INDEX(S_INDEX)) u_dirty (
        .clk(clk), .clr(rst), .load(dirty_ld), .idx(index), .din(dirty_d), .dout(dirty_q));

    // Lay the enabled bytes of the CPU word over the resident line
    always_comb begin
        merged = line_q;
        for (int b = 0; b < 4; b++)
            if (mem_byte_enable[b]) merged[{word, 2'(b), 3'b000} +: 8] = mem_wdata[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state   = state;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        data_ld      = 1'b0;
        line_d       = merged;
        tag_ld       = 1'b0;
        valid_ld     = 1'b0;
        valid_d      = 1'b0;
        dirty_ld     = 1'b0;
        dirty_d      = 1'b0;
        case (state)
            IDLE: if (req) begin
                if (hit) begin
                    mem_resp  = 1'b1;
                    mem_rdata = mem_write ? '0 : line_q[{word, 5'b00000} +: 32];
                    data_ld   = mem_write;
                    dirty_ld  = mem_write;
                    dirty_d   = 1'b1;
                end else begin
                    next_state = (valid_q && dirty_q) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q, index, 5'b00000};
                pmem_wdata   = line_q;
                if (pmem_resp) begin
                    dirty_ld   = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, index, 5'b00000};
                if (pmem_resp) begin
                    data_ld    = 1'b1;
                    line_d     = pmem_rdata;
                    tag_ld     = 1'b1;
                    valid_ld   = 1'b1;
                    valid_d    = 1'b1;
                    dirty_ld   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end
endmodule
